// File: rtl/mem_data_arbiter_pkg.sv
// Shared constants, access-size codes and FSM encoding for the data-memory arbiter.
// The memory geometry here must match the dataMem instance the arbiter fronts.
package mem_data_arbiter_pkg;

  localparam int MEM_ADDR_WIDTH = 32;
  localparam int MEM_DATA_WIDTH = 32;
  localparam int MEM_DEPTH      = 64;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_ACCESS = 2'b01,
    ARB_RESP   = 2'b10
  } arb_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane datapath: store lane enables and replicated data, load alignment and
// extension, and the alignment check for a given size and low address bits.
module mem_lane_align
  import mem_data_arbiter_pkg::*;
(
  input  logic [1:0]                size_i,
  input  logic [1:0]                addr_lo_i,
  input  logic                      unsigned_i,
  input  logic [MEM_DATA_WIDTH-1:0] wdata_i,
  input  logic [MEM_DATA_WIDTH-1:0] rdata_i,
  output logic [3:0]                lanes_o,
  output logic [MEM_DATA_WIDTH-1:0] wdata_o,
  output logic [MEM_DATA_WIDTH-1:0] load_o,
  output logic                      misalign_o
);

  logic [MEM_DATA_WIDTH-1:0] shifted;
  logic                      sign_bit;

  always_comb begin
    lanes_o    = 4'b0000;
    wdata_o    = '0;
    load_o     = '0;
    misalign_o = 1'b0;
    sign_bit   = 1'b0;
    shifted    = rdata_i >> {addr_lo_i, 3'b000};
    case (size_i)
      SIZE_BYTE: begin
        lanes_o  = 4'b0001 << addr_lo_i;
        wdata_o  = {4{wdata_i[7:0]}};
        sign_bit = ~unsigned_i & shifted[7];
        load_o   = {{24{sign_bit}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        lanes_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o    = {2{wdata_i[15:0]}};
        sign_bit   = ~unsigned_i & shifted[15];
        load_o     = {{16{sign_bit}}, shifted[15:0]};
        misalign_o = addr_lo_i[0];
      end
      SIZE_WORD: begin
        lanes_o    = 4'b1111;
        wdata_o    = wdata_i;
        load_o     = shifted;
        misalign_o = |addr_lo_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_data_arbiter.sv
// Round-robin two-port arbiter and access sequencer in front of the single-port dataMem.
// Each grant runs IDLE -> ACCESS -> RESP; rejected accesses skip ACCESS and never touch memory.
module mem_data_arbiter
  import mem_data_arbiter_pkg::*;
#(
  parameter int TRANSFER_WIDTH = 4,
  parameter int MEM_BYTES      = 4 * MEM_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      p0_req,
  input  logic                      p0_we,
  input  logic [MEM_ADDR_WIDTH-1:0] p0_addr,
  input  logic [MEM_DATA_WIDTH-1:0] p0_wdata,
  input  logic [1:0]                p0_size,
  input  logic                      p0_unsigned,
  output logic                      p0_rsp_valid,
  output logic [MEM_DATA_WIDTH-1:0] p0_rdata,
  output logic                      p0_err,
  input  logic                      p1_req,
  input  logic                      p1_we,
  input  logic [MEM_ADDR_WIDTH-1:0] p1_addr,
  input  logic [MEM_DATA_WIDTH-1:0] p1_wdata,
  input  logic [1:0]                p1_size,
  input  logic                      p1_unsigned,
  output logic                      p1_rsp_valid,
  output logic [MEM_DATA_WIDTH-1:0] p1_rdata,
  output logic                      p1_err,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_DATA_WIDTH-1:0] mem_wdata,
  output logic [TRANSFER_WIDTH-1:0] mem_write_transfer,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rdata
);

  arb_state_e                     state_q;
  logic                           last_grant_q, grant_q, we_q, uns_q;
  logic [1:0]                     size_q, addr_lo_q;
  logic [1:0]                     rsp_valid_q, err_q;
  logic [1:0][MEM_DATA_WIDTH-1:0] rdata_q;
  logic                           mem_we_q;
  logic [MEM_ADDR_WIDTH-1:0]      mem_addr_q;
  logic [MEM_DATA_WIDTH-1:0]      mem_wdata_q;
  logic [TRANSFER_WIDTH-1:0]      mem_wt_q;

  logic                      any_req, win_d, err_d;
  logic                      sel_we, sel_uns;
  logic [MEM_ADDR_WIDTH-1:0] sel_addr;
  logic [MEM_DATA_WIDTH-1:0] sel_wdata;
  logic [1:0]                sel_size, al_size, al_addr_lo;
  logic                      al_uns, misalign;
  logic [3:0]                lanes;
  logic [MEM_DATA_WIDTH-1:0] wdata_rep, load_ext;

  // On a tie the port that was not served last wins.
  always_comb begin
    any_req   = p0_req | p1_req;
    win_d     = (p0_req && p1_req) ? ~last_grant_q : p1_req;
    sel_we    = win_d ? p1_we       : p0_we;
    sel_addr  = win_d ? p1_addr     : p0_addr;
    sel_wdata = win_d ? p1_wdata    : p0_wdata;
    sel_size  = win_d ? p1_size     : p0_size;
    sel_uns   = win_d ? p1_unsigned : p0_unsigned;
  end

  // IDLE feeds the candidate request to the lane logic (store setup); ACCESS feeds the latch (load).
  always_comb begin
    al_size    = (state_q == ARB_IDLE) ? sel_size      : size_q;
    al_addr_lo = (state_q == ARB_IDLE) ? sel_addr[1:0] : addr_lo_q;
    al_uns     = (state_q == ARB_IDLE) ? sel_uns       : uns_q;
    err_d      = (sel_size == 2'b11) | misalign |
                 (sel_addr >= MEM_ADDR_WIDTH'(MEM_BYTES));
  end

  mem_lane_align u_align (
    .size_i     (al_size),
    .addr_lo_i  (al_addr_lo),
    .unsigned_i (al_uns),
    .wdata_i    (sel_wdata),
    .rdata_i    (mem_rdata),
    .lanes_o    (lanes),
    .wdata_o    (wdata_rep),
    .load_o     (load_ext),
    .misalign_o (misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= 2'b00;
      addr_lo_q    <= 2'b00;
      rsp_valid_q  <= 2'b00;
      err_q        <= 2'b00;
      rdata_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wt_q     <= '0;
    end else begin
      // Response and memory strobes are single-cycle; clear them unless re-set below.
      rsp_valid_q <= 2'b00;
      err_q       <= 2'b00;
      rdata_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wt_q    <= '0;
      case (state_q)
        ARB_IDLE: begin
          if (any_req) begin
            grant_q      <= win_d;
            last_grant_q <= win_d;
            we_q         <= sel_we;
            uns_q        <= sel_uns;
            size_q       <= sel_size;
            addr_lo_q    <= sel_addr[1:0];
            if (err_d) begin
              state_q            <= ARB_RESP;
              rsp_valid_q[win_d] <= 1'b1;
              err_q[win_d]       <= 1'b1;
            end else begin
              state_q     <= ARB_ACCESS;
              mem_we_q    <= sel_we;
              mem_addr_q  <= {sel_addr[MEM_ADDR_WIDTH-1:2], 2'b00};
              mem_wdata_q <= sel_we ? wdata_rep : '0;
              mem_wt_q    <= sel_we ? TRANSFER_WIDTH'(lanes) : '0;
            end
          end
        end
        ARB_ACCESS: begin
          state_q              <= ARB_RESP;
          rsp_valid_q[grant_q] <= 1'b1;
          if (!we_q) rdata_q[grant_q] <= load_ext;
        end
        ARB_RESP: state_q <= ARB_IDLE;
        default:  state_q <= ARB_IDLE;
      endcase
    end
  end

  assign p0_rsp_valid       = rsp_valid_q[0];
  assign p1_rsp_valid       = rsp_valid_q[1];
  assign p0_err             = err_q[0];
  assign p1_err             = err_q[1];
  assign p0_rdata           = rdata_q[0];
  assign p1_rdata           = rdata_q[1];
  assign mem_we             = mem_we_q;
  assign mem_addr           = mem_addr_q;
  assign mem_wdata          = mem_wdata_q;
  assign mem_write_transfer = mem_wt_q;

endmodule
